// File: rtl/vproc_mem_responder.sv
// vproc_mem_responder: word-addressed RAM window on the VProc bus with
// programmable wait states and one-cycle WRAck/RDAck handshakes.
module vproc_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned FIRST_WAIT = 0,
    parameter int unsigned BEAT_WAIT  = 0,
    parameter logic [31:0] RD_FILL    = 32'hDEAD_BEEF
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] DataOut,
    input  logic        BurstFirst,
    input  logic        BurstLast,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    output logic        Hit,
    output logic        ProtErr
);

    localparam int unsigned MEM_DEPTH = 32'd1 << MEM_AW;
    localparam int unsigned MAX_WAIT  = (FIRST_WAIT > BEAT_WAIT) ? FIRST_WAIT : BEAT_WAIT;
    localparam int unsigned CNT_W     = (MAX_WAIT < 32'd2) ? 32'd1 : $clog2(MAX_WAIT + 32'd1);
    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(FIRST_WAIT);
    localparam logic [CNT_W-1:0] BEAT_CNT  = CNT_W'(BEAT_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic                is_wr_q, is_wr_d;
    logic                last_q, last_d;
    logic                in_burst_q, in_burst_d;
    logic [31:0]         data_in_q, data_in_d;
    logic                wr_ack_q, wr_ack_d;
    logic                rd_ack_q, rd_ack_d;
    logic                hit_q, hit_d;
    logic                prot_err_q, prot_err_d;

    logic [31:0]         offset_s;
    logic                hit_s;
    logic                req_s;
    logic [CNT_W-1:0]    load_s;
    logic                go_ack_s;
    logic [MEM_AW-1:0]   acc_idx_s;
    logic                mem_we_s;
    logic                mem_re_s;

    logic [31:0]         mem [MEM_DEPTH];

    // Address decode: the unsigned offset wraps, so addresses below BASE_ADDR miss.
    always_comb begin
        offset_s = Addr - BASE_ADDR;
        hit_s    = ((offset_s >> MEM_AW) == 32'd0);
        req_s    = (WE | RD) & hit_s;
        load_s   = (BurstFirst | ~in_burst_q) ? FIRST_CNT : BEAT_CNT;
    end

    // FSM next-state, request capture and burst tracking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        is_wr_d    = is_wr_q;
        last_d     = last_q;
        in_burst_d = in_burst_q;
        go_ack_s   = 1'b0;
        acc_idx_s  = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    idx_d   = offset_s[MEM_AW-1:0];
                    is_wr_d = WE;
                    last_d  = BurstLast;
                    if (BurstFirst) begin
                        in_burst_d = 1'b1;
                    end else begin
                        in_burst_d = in_burst_q;
                    end
                    if (load_s == '0) begin
                        // Zero wait: the access completes on this very edge.
                        state_d   = ST_ACK;
                        cnt_d     = '0;
                        go_ack_s  = 1'b1;
                        acc_idx_s = offset_s[MEM_AW-1:0];
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = load_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1'b1)) begin
                    state_d  = ST_ACK;
                    cnt_d    = '0;
                    go_ack_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (last_q) begin
                    in_burst_d = 1'b0;
                end else begin
                    in_burst_d = in_burst_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: ack generation, read data capture, decode flag and sticky error.
    always_comb begin
        mem_we_s   = go_ack_s & is_wr_d;
        mem_re_s   = go_ack_s & ~is_wr_d;
        wr_ack_d   = mem_we_s;
        rd_ack_d   = mem_re_s;
        hit_d      = req_s;
        prot_err_d = prot_err_q | (WE & RD & hit_s);
        if (mem_re_s) begin
            data_in_d = mem[acc_idx_s];
        end else begin
            data_in_d = data_in_q;
        end
    end

    // State and output registers; memory contents survive reset.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            is_wr_q    <= 1'b0;
            last_q     <= 1'b0;
            in_burst_q <= 1'b0;
            data_in_q  <= RD_FILL;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            hit_q      <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            is_wr_q    <= is_wr_d;
            last_q     <= last_d;
            in_burst_q <= in_burst_d;
            data_in_q  <= data_in_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            hit_q      <= hit_d;
            prot_err_q <= prot_err_d;
        end
    end

    // Memory write port; a reset on the completing edge drops the write.
    always_ff @(posedge Clk) begin
        if (nReset && mem_we_s) begin
            mem[acc_idx_s] <= DataOut;
        end
    end

    assign DataIn  = data_in_q;
    assign WRAck   = wr_ack_q;
    assign RDAck   = rd_ack_q;
    assign Hit     = hit_q;
    assign ProtErr = prot_err_q;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Scoreboard bench for vproc_mem_responder: four differently parameterised
// instances, directed accesses, expected acks queued and checked by a monitor.
module tb_vproc_mem_responder;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [31:0]   addr [N];
    logic [31:0]   dout [N];
    logic [N-1:0]  we, rd, bfirst, blast;
    logic [31:0]   din [N];
    logic [N-1:0]  wrack, rdack, hit, perr;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    typedef struct {
        int          inst;
        logic        is_wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    vproc_mem_responder u_a (
        .Clk(clk), .nReset(n_reset), .Addr(addr[0]), .WE(we[0]), .RD(rd[0]),
        .DataOut(dout[0]), .BurstFirst(bfirst[0]), .BurstLast(blast[0]),
        .DataIn(din[0]), .WRAck(wrack[0]), .RDAck(rdack[0]), .Hit(hit[0]), .ProtErr(perr[0])
    );

    vproc_mem_responder #(.FIRST_WAIT(3)) u_b (
        .Clk(clk), .nReset(n_reset), .Addr(addr[1]), .WE(we[1]), .RD(rd[1]),
        .DataOut(dout[1]), .BurstFirst(bfirst[1]), .BurstLast(blast[1]),
        .DataIn(din[1]), .WRAck(wrack[1]), .RDAck(rdack[1]), .Hit(hit[1]), .ProtErr(perr[1])
    );

    vproc_mem_responder #(.FIRST_WAIT(2), .BEAT_WAIT(1)) u_c (
        .Clk(clk), .nReset(n_reset), .Addr(addr[2]), .WE(we[2]), .RD(rd[2]),
        .DataOut(dout[2]), .BurstFirst(bfirst[2]), .BurstLast(blast[2]),
        .DataIn(din[2]), .WRAck(wrack[2]), .RDAck(rdack[2]), .Hit(hit[2]), .ProtErr(perr[2])
    );

    vproc_mem_responder #(.BASE_ADDR(32'h0000_0100), .MEM_AW(4)) u_d (
        .Clk(clk), .nReset(n_reset), .Addr(addr[3]), .WE(we[3]), .RD(rd[3]),
        .DataOut(dout[3]), .BurstFirst(bfirst[3]), .BurstLast(blast[3]),
        .DataIn(din[3]), .WRAck(wrack[3]), .RDAck(rdack[3]), .Hit(hit[3]), .ProtErr(perr[3])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ack pops one expected entry and is checked against it.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (wrack[i] === 1'b1 || rdack[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: inst %0d wrack=%b rdack=%b at cycle %0d, no ack expected",
                             i, wrack[i], rdack[i], cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_inst", 32'(i), 32'(e.inst));
                    check("ack_wr", {31'd0, wrack[i]}, {31'd0, e.is_wr});
                    check("ack_rd", {31'd0, rdack[i]}, {31'd0, ~e.is_wr});
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (!e.is_wr) begin
                        check("read_data", din[i], e.data);
                    end
                end
            end
        end
    end

    // One VProc access: drive at a negedge, hold until ack, release one cycle later.
    task automatic access(input int inst, input logic [31:0] a, input logic w, input logic r,
                          input logic [31:0] d, input logic bf, input logic bl,
                          input int wt, input logic [31:0] exp_d);
        exp_t e;
        bit   seen;
        addr[inst]   = a;
        dout[inst]   = d;
        we[inst]     = w;
        rd[inst]     = r;
        bfirst[inst] = bf;
        blast[inst]  = bl;
        e.inst  = inst;
        e.is_wr = w;
        e.data  = exp_d;
        e.cyc   = cyc + 1 + wt;
        exp_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check($sformatf("hit_inst%0d_%h", inst, a), {31'd0, hit[inst]}, 32'd1);
            end
            seen = (wrack[inst] === 1'b1) || (rdack[inst] === 1'b1);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: inst %0d addr %h got no ack in 40 cycles, ack required", inst, a);
            exp_q.delete();
        end
        @(negedge clk);
        we[inst]     = 1'b0;
        rd[inst]     = 1'b0;
        bfirst[inst] = 1'b0;
        blast[inst]  = 1'b0;
    endtask

    // Read outside the window: Hit stays low and the monitor flags any ack.
    task automatic miss(input int inst, input logic [31:0] a);
        addr[inst] = a;
        rd[inst]   = 1'b1;
        @(negedge clk);
        check($sformatf("miss_hit_inst%0d_%h", inst, a), {31'd0, hit[inst]}, 32'd0);
        repeat (6) @(negedge clk);
        rd[inst] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            addr[i] = 32'd0;
            dout[i] = 32'd0;
        end
        we = '0; rd = '0; bfirst = '0; blast = '0;
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_wrack_%0d", i), {31'd0, wrack[i]}, 32'd0);
            check($sformatf("rst_rdack_%0d", i), {31'd0, rdack[i]}, 32'd0);
            check($sformatf("rst_hit_%0d", i), {31'd0, hit[i]}, 32'd0);
            check($sformatf("rst_proterr_%0d", i), {31'd0, perr[i]}, 32'd0);
            check($sformatf("rst_datain_%0d", i), din[i], 32'hDEAD_BEEF);
        end
        n_reset = 1'b1;
        @(negedge clk);

        // Zero-wait write then read.
        access(0, 32'h10, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 0, 32'h0);
        access(0, 32'h10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 32'h1234_5678);

        // Three wait states.
        access(1, 32'h4, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 3, 32'h0);
        access(1, 32'h4, 0, 1'b1, 32'h0, 1'b0, 1'b0, 3, 32'h0BAD_F00D);

        // Four-beat bursts: first beat FIRST_WAIT, others BEAT_WAIT.
        for (int b = 0; b < 4; b++) begin
            access(2, 32'h20 + 32'(b), 1'b1, 1'b0, 32'(b + 1), b == 0, b == 3, (b == 0) ? 2 : 1, 32'h0);
        end
        for (int b = 0; b < 4; b++) begin
            access(2, 32'h20 + 32'(b), 1'b0, 1'b1, 32'h0, b == 0, b == 3, (b == 0) ? 2 : 1, 32'(b + 1));
        end
        access(2, 32'h21, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 2, 32'd2);

        // Window edges with BASE_ADDR=0x100, 16 words.
        access(3, 32'h10F, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 0, 32'h0);
        access(3, 32'h100, 1'b1, 1'b0, 32'h1357_9BDF, 1'b0, 1'b0, 0, 32'h0);
        miss(3, 32'h110);
        miss(3, 32'h0FF);
        access(3, 32'h10F, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 32'hCAFE_F00D);
        access(3, 32'h100, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 32'h1357_9BDF);

        // Reset while a write sits in WAIT: write dropped, no ack.
        access(1, 32'h8, 1'b1, 1'b0, 32'hA5, 1'b0, 1'b0, 3, 32'h0);
        addr[1] = 32'h8;
        dout[1] = 32'h77;
        we[1]   = 1'b1;
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        we[1]   = 1'b0;
        check("rst_mid_datain", din[1], 32'hDEAD_BEEF);
        check("rst_mid_wrack", {31'd0, wrack[1]}, 32'd0);
        repeat (6) @(negedge clk);
        access(1, 32'h8, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3, 32'hA5);

        // WE and RD together: write, sticky ProtErr.
        check("proterr_before", {31'd0, perr[0]}, 32'd0);
        access(0, 32'h0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 0, 32'h0);
        check("proterr_set", {31'd0, perr[0]}, 32'd1);
        access(0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 32'h55);
        check("proterr_sticky", {31'd0, perr[0]}, 32'd1);
        access(0, 32'h10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 32'h1234_5678);

        repeat (3) @(negedge clk);
        check("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
